// File: rtl/el2_lsu_bus_clken_gen.sv
// Purpose: generates the core-to-bus clock-ratio enable and runs a quiesce handshake around ratio changes.
// Latency: enable is registered; a ratio request completes 2 cycles after accept at best (drain time + ratio at worst).
// Backpressure: cfg_ratio_ready is low outside RUN; the requester holds cfg_ratio_valid until it is accepted.
module el2_lsu_bus_clken_gen #(
  parameter int RATIO_W     = 3,
  parameter int RESET_RATIO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_ratio_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ratio_ready,
  output logic               cfg_ratio_done,
  input  logic               lsu_bus_buffer_empty_any,
  input  logic               lsu_busreq_r,
  input  logic               dec_tlu_force_halt,
  output logic               lsu_bus_quiesce,
  output logic               lsu_bus_clk_en,
  output logic [RATIO_W-1:0] bus_ratio_cur
);

  localparam logic [RATIO_W-1:0] ONE = RATIO_W'(1);

  // A zero reset ratio would mean "never enable"; treat it as divide-by-one,
  // the same way a zero request is treated.
  localparam logic [RATIO_W-1:0] RST_RATIO =
    (RESET_RATIO == 0) ? ONE : RATIO_W'(RESET_RATIO);

  // With cnt reset to 0, the enable is high at reset only for divide-by-one.
  localparam logic RST_EN = (RST_RATIO == ONE);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [RATIO_W-1:0] ratio_q,   ratio_d;
  logic [RATIO_W-1:0] cnt_q,     cnt_d;
  logic [RATIO_W-1:0] pending_q, pending_d;
  logic               clk_en_q,  clk_en_d;
  logic               done_q,    done_d;

  logic [RATIO_W-1:0] cnt_last;
  logic               cnt_wrap;
  logic               drain_ok;

  // Last count value of the current bus cycle; ratio is never zero, so no underflow.
  assign cnt_last = ratio_q - ONE;

  // The >= keeps the counter bounded even if it were ever above ratio-1.
  assign cnt_wrap = (cnt_q >= cnt_last);

  // Bus side is idle, or a force halt says we must not wait for it.
  assign drain_ok = (lsu_bus_buffer_empty_any & ~lsu_busreq_r) | dec_tlu_force_halt;

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d         = state_q;
    ratio_d         = ratio_q;
    pending_d       = pending_q;
    cnt_d           = cnt_wrap ? '0 : (cnt_q + ONE);
    done_d          = 1'b0;
    cfg_ratio_ready = 1'b0;
    lsu_bus_quiesce = 1'b0;

    case (state_q)
      ST_RUN: begin
        cfg_ratio_ready = 1'b1;
        if (cfg_ratio_valid) begin
          pending_d = (cfg_ratio == '0) ? ONE : cfg_ratio;
          state_d   = ST_DRAIN;
        end
      end

      // Old ratio stays live; new bus requests are held off until traffic drains.
      ST_DRAIN: begin
        lsu_bus_quiesce = 1'b1;
        if (drain_ok) begin
          state_d = ST_SWITCH;
        end
      end

      // Only switch on a cycle whose enable is high, so the change lands
      // exactly on a bus-cycle boundary and the new count starts at 0.
      ST_SWITCH: begin
        lsu_bus_quiesce = 1'b1;
        if (clk_en_q) begin
          state_d = ST_RUN;
          ratio_d = pending_q;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Enable follows the count it will be paired with next cycle.
    clk_en_d = (cnt_d == (ratio_d - ONE));
  end

  // State, ratio, counter and the registered enable/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ratio_q   <= RST_RATIO;
      cnt_q     <= '0;
      pending_q <= '0;
      clk_en_q  <= RST_EN;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      clk_en_q  <= clk_en_d;
      done_q    <= done_d;
    end
  end

  assign lsu_bus_clk_en = clk_en_q;
  assign cfg_ratio_done = done_q;
  assign bus_ratio_cur  = ratio_q;

endmodule

// File: tb/tb_el2_lsu_bus_clken_gen.sv
// Directed bench for the bus clock-enable generator.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived per cycle.
module tb_el2_lsu_bus_clken_gen;

  localparam int RATIO_W = 3;

  logic               clk;
  logic               rst;
  logic               cfg_ratio_valid;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_ratio_ready;
  logic               cfg_ratio_done;
  logic               lsu_bus_buffer_empty_any;
  logic               lsu_busreq_r;
  logic               dec_tlu_force_halt;
  logic               lsu_bus_quiesce;
  logic               lsu_bus_clk_en;
  logic [RATIO_W-1:0] bus_ratio_cur;

  int total = 0;
  int bad   = 0;

  el2_lsu_bus_clken_gen #(
    .RATIO_W    (RATIO_W),
    .RESET_RATIO(1)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .cfg_ratio_valid         (cfg_ratio_valid),
    .cfg_ratio               (cfg_ratio),
    .cfg_ratio_ready         (cfg_ratio_ready),
    .cfg_ratio_done          (cfg_ratio_done),
    .lsu_bus_buffer_empty_any(lsu_bus_buffer_empty_any),
    .lsu_busreq_r            (lsu_busreq_r),
    .dec_tlu_force_halt      (dec_tlu_force_halt),
    .lsu_bus_quiesce         (lsu_bus_quiesce),
    .lsu_bus_clk_en          (lsu_bus_clk_en),
    .bus_ratio_cur           (bus_ratio_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full observable snapshot: enable, ratio, ready, quiesce, done.
  task automatic chk_all(input string tag, input logic en, input logic [RATIO_W-1:0] r,
                         input logic rdy, input logic q, input logic dn);
    chk({tag, ".en"},      32'(lsu_bus_clk_en),  32'(en));
    chk({tag, ".ratio"},   32'(bus_ratio_cur),   32'(r));
    chk({tag, ".ready"},   32'(cfg_ratio_ready), 32'(rdy));
    chk({tag, ".quiesce"}, 32'(lsu_bus_quiesce), 32'(q));
    chk({tag, ".done"},    32'(cfg_ratio_done),  32'(dn));
  endtask

  initial begin
    rst                      = 1'b1;
    cfg_ratio_valid          = 1'b0;
    cfg_ratio                = '0;
    lsu_bus_buffer_empty_any = 1'b1;
    lsu_busreq_r             = 1'b0;
    dec_tlu_force_halt       = 1'b0;

    // ---- Reset state, ratio 1: enable every cycle ----
    tick();
    tick();
    chk_all("reset", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("r1_run0", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("r1_run1.en", 32'(lsu_bus_clk_en), 32'd1);

    // ---- Request ratio 3 with the bus idle: 2 quiesce cycles then done ----
    cfg_ratio_valid = 1'b1;
    cfg_ratio       = 3'd3;
    tick();                                   // accepted -> DRAIN
    cfg_ratio_valid = 1'b0;
    chk_all("r3_drain", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    tick();                                   // -> SWITCH, enable high
    chk_all("r3_switch", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    tick();                                   // switched: cnt=0
    chk_all("r3_done", 1'b0, 3'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();                                 // cnt = 1,2,0,1,2,0 ... ends at cnt=2 (i=4)? see below
      chk($sformatf("r3_pat%0d", i), 32'(lsu_bus_clk_en), 32'((i % 3) == 1));
      if (i == 4) break;
    end
    // Now at cnt=2 (enable high), ratio 3.

    // ---- Request 2 while buffer busy for 5 cycles ----
    cfg_ratio_valid          = 1'b1;
    cfg_ratio                = 3'd2;
    lsu_bus_buffer_empty_any = 1'b0;
    tick();                                   // accepted -> DRAIN, cnt=0
    cfg_ratio_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("r2_drain%0d", i), ((i % 3) == 2), 3'd3, 1'b0, 1'b1, 1'b0);
      tick();
    end
    // Sixth DRAIN cycle, cnt=2; buffer drains now.
    chk("r2_drain5.quiesce", 32'(lsu_bus_quiesce), 32'd1);
    lsu_bus_buffer_empty_any = 1'b1;
    tick();                                   // -> SWITCH, cnt=0
    chk_all("r2_sw0", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();                                   // cnt=1
    chk_all("r2_sw1", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();                                   // cnt=2, enable high
    chk_all("r2_sw2", 1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();                                   // switched to 2, cnt=0
    chk_all("r2_done", 1'b0, 3'd2, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("r2_pat%0d", i), 32'(lsu_bus_clk_en), 32'((i % 2) == 1));
    end
    tick();                                   // cnt=0, enable low

    // ---- Force halt in RUN does nothing; then request 4 with halt skipping the drain ----
    dec_tlu_force_halt       = 1'b1;
    lsu_bus_buffer_empty_any = 1'b0;
    tick();                                   // cnt=1
    chk_all("halt_run", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    cfg_ratio_valid = 1'b1;
    cfg_ratio       = 3'd4;
    tick();                                   // accepted -> DRAIN, cnt=0
    cfg_ratio_valid = 1'b0;
    chk_all("r4_drain", 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();                                   // halt -> SWITCH, cnt=1 enable high
    chk_all("r4_switch", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    tick();                                   // switched to 4
    chk_all("r4_done", 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    dec_tlu_force_halt       = 1'b0;
    lsu_bus_buffer_empty_any = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("r4_pat%0d", i), 32'(lsu_bus_clk_en), 32'(i == 3));
    end
    // Now cnt=3, enable high.

    // ---- Request 0 (-> 1); a different value held during DRAIN is ignored ----
    cfg_ratio_valid          = 1'b1;
    cfg_ratio                = 3'd0;
    lsu_bus_buffer_empty_any = 1'b0;
    tick();                                   // accepted -> DRAIN, cnt=0
    cfg_ratio = 3'd5;
    chk_all("r0_drain0", 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    tick();                                   // cnt=1
    chk_all("r0_drain1", 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    tick();                                   // cnt=2
    lsu_bus_buffer_empty_any = 1'b1;
    tick();                                   // -> SWITCH, cnt=3 enable high
    chk_all("r0_switch", 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    tick();                                   // switched to 1
    chk_all("r0_done", 1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    cfg_ratio_valid = 1'b0;
    tick();
    chk_all("r0_run1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);

    // ---- Reset while in SWITCH with pending 5 ----
    cfg_ratio_valid = 1'b1;
    cfg_ratio       = 3'd5;
    tick();                                   // -> DRAIN
    cfg_ratio_valid = 1'b0;
    tick();                                   // -> SWITCH
    chk_all("r5_switch", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();                                   // reset instead of switching to 5
    chk_all("rst_sw", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("rst_after", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/el2_lsu_bus_clken_gen.md
Name: el2_lsu_bus_clken_gen

Overview:
- Produces `lsu_bus_clk_en`, the core-to-bus clock-ratio enable consumed by the LSU clock domain and the bus buffer.
- Holds a programmable divide ratio N and emits a one-cycle enable every N core cycles.
- Runs a quiesce handshake before a ratio change, so a change never lands while bus traffic is in flight or mid-bus-cycle.
- Sits beside the LSU clock domain; its enable gates the obuf and busm clock enables.

Parameters:
- RATIO_W, 3, width of the ratio field; maximum ratio is 2^RATIO_W-1.
- RESET_RATIO, 1, divide ratio loaded at reset (1 = bus clock equals core clock).

Ports:
- clk  input  1  core clock, free-running while the LSU is active
- rst  input  1  synchronous reset, active-high
- cfg_ratio_valid  input  1  new ratio request
- cfg_ratio  input  RATIO_W  requested ratio; 0 is treated as 1
- cfg_ratio_ready  output  1  request can be accepted
- cfg_ratio_done  output  1  one-cycle pulse when the new ratio takes effect
- lsu_bus_buffer_empty_any  input  1  bus buffer empty
- lsu_busreq_r  input  1  bus request in r stage
- dec_tlu_force_halt  input  1  force halt; bypasses the drain wait
- lsu_bus_quiesce  output  1  high while draining or switching; LSU must not start new bus requests
- lsu_bus_clk_en  output  1  bus clock enable pulse, flop-driven
- bus_ratio_cur  output  RATIO_W  ratio currently in effect

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous, active-high, sampled on the rising edge.
- Reset values:
  - state = RUN, ratio = RESET_RATIO, cnt = 0, pending = 0.
  - cfg_ratio_ready = 1, cfg_ratio_done = 0, lsu_bus_quiesce = 0, bus_ratio_cur = RESET_RATIO.
  - lsu_bus_clk_en = 1 if RESET_RATIO == 1, else 0.
- Counter (cnt, RATIO_W bits):
  - Counts 0..ratio-1 and wraps to 0 after ratio-1.
  - lsu_bus_clk_en is registered. It is high exactly in cycles where cnt == ratio-1.
  - With ratio 1 it is high every cycle. With ratio N it is high for 1 of every N cycles, first pulse N-1 cycles after cnt = 0.
- RUN:
  - cfg_ratio_ready = 1.
  - On cfg_ratio_valid & cfg_ratio_ready, capture pending = (cfg_ratio == 0 ? 1 : cfg_ratio) and go to DRAIN.
  - Counter keeps running.
- DRAIN:
  - cfg_ratio_ready = 0, lsu_bus_quiesce = 1. Old ratio stays in effect.
  - Go to SWITCH when (lsu_bus_buffer_empty_any & ~lsu_busreq_r) | dec_tlu_force_halt.
- SWITCH:
  - lsu_bus_quiesce = 1.
  - Wait for a cycle with lsu_bus_clk_en = 1; this aligns the change to a bus-cycle boundary.
  - On the next edge: ratio <= pending, cnt <= 0, cfg_ratio_done pulses for one cycle, state <= RUN.
  - In that first RUN cycle, lsu_bus_clk_en = (pending == 1).
- Request handling:
  - A request is accepted only in RUN. cfg_ratio_valid in DRAIN or SWITCH is ignored; the requester holds valid until ready.
  - Request equal to the current ratio still runs the full handshake, and cfg_ratio_done still pulses.
- Latency: minimum accept-to-done is 2 cycles (drain condition met immediately, enable high at SWITCH entry). Maximum is drain time + ratio cycles.
- Boundary conditions:
  - Drain condition true in the same cycle as acceptance: DRAIN still lasts one cycle.
  - Force halt asserted in RUN has no effect on state.
  - rst mid-DRAIN or mid-SWITCH discards pending and returns to the reset values next cycle.
  - Counter never exceeds ratio-1; a ratio change always resets cnt.

Test Plan:
- Reset with RESET_RATIO=1 -> lsu_bus_clk_en = 1 every cycle; bus_ratio_cur = 1; ready = 1; quiesce = 0.
- Request ratio 3 with buffer empty and busreq_r = 0 -> quiesce = 1 for 2 cycles, done pulses. Then lsu_bus_clk_en pattern 0,0,1 repeating; bus_ratio_cur = 3.
- At ratio 3, request 2 while lsu_bus_buffer_empty_any = 0 for 5 cycles -> stays in DRAIN with enable still every 3rd cycle. After empty, switches on the next enable pulse, then pattern 0,1 repeating.
- Request 4 with buffer non-empty plus dec_tlu_force_halt = 1 -> drain skipped; switch on the next enable; ratio = 4.
- cfg_ratio = 0 -> ratio becomes 1, enable every cycle. cfg_ratio_valid held during DRAIN with a different value -> ignored; first request's value wins.
- rst asserted in SWITCH with pending = 5 -> next cycle ratio = RESET_RATIO, cnt = 0, quiesce = 0, no done pulse.
